// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial unsigned adder/subtractor, one bit per clock, LSB first
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st;
    logic [WIDTH-1:0] a_sh, b_sh, s_msb;
    logic [CW-1:0] cnt;
    logic mode, c, s, c_next, ai, bi;
    assign in_ready  = st == IDLE && !rst;
    assign out_valid = st == DONE;
    always_comb begin
        ai = a_sh[0];
        bi = b_sh[0];
        s = ai ^ bi ^ c;
        c_next = mode ? (~ai & bi) | (c & ~(ai ^ bi)) : (ai & bi) | (c & (ai ^ bi));
        s_msb = '0;
        s_msb[WIDTH-1] = s;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            a_sh <= '0;
            b_sh <= '0;
            mode <= 1'b0;
            c <= 1'b0;
            cnt <= '0;
            result <= '0;
            cout <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    a_sh <= a;
                    b_sh <= b;
                    mode <= m;
                    c <= 1'b0;
                    cnt <= '0;
                    st <= RUN;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    result <= (result >> 1) | s_msb;
                    c <= c_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout <= c_next;
                        st <= DONE;
                    end
                end
                DONE: if (out_ready) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed checks of serial_add_sub against an arithmetic model
module tb_serial_add_sub;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, m = 0, out_valid, out_ready = 0, cout;
    logic [7:0] a = 0, b = 0, result;
    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    logic [8:0] q[$];
    logic prev_ov = 0, held = 0, held_c = 0;
    logic [7:0] held_r = 0;

    serial_add_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // expected outcome of one accepted operation, from plain 9-bit arithmetic
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic md);
        return md ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_ov = 0;
            held = 0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, m));
                acc_cyc = cyc + 1;
            end
            if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, 8);
            if (out_valid) chk("in_ready_done", in_ready, 0);
            if (held && out_valid) begin
                chk("hold_result", result, held_r);
                chk("hold_cout", cout, held_c);
            end
            held = out_valid && !out_ready;
            held_r = result;
            held_c = cout;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output got=%0h want=none", {cout, result});
                end else begin
                    logic [8:0] e;
                    e = q.pop_front();
                    chk("model_result", result, e[7:0]);
                    chk("model_cout", cout, e[8]);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xm);
        int n = 0;
        a = xa; b = xb; m = xm; in_valid = 1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_ov;
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
            a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic recv(input int hold, output logic [7:0] r, output logic c);
        wait_ov();
        repeat (hold) begin
            @(posedge clk); #1;
        end
        r = result; c = cout;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic op(input string nm, input logic [7:0] xa, input logic [7:0] xb, input logic xm,
                      input logic [7:0] er, input logic ec);
        logic [7:0] r;
        logic c;
        send(xa, xb, xm);
        recv(0, r, c);
        chk({nm, "_r"}, r, er);
        chk({nm, "_c"}, c, ec);
    endtask

    initial begin
        logic [7:0] r0, rr;
        logic c0, cc;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        op("add_5a_3c", 8'h5a, 8'h3c, 0, 8'h96, 0);
        op("add_ff_01", 8'hff, 8'h01, 0, 8'h00, 1);
        op("sub_5a_3c", 8'h5a, 8'h3c, 1, 8'h1e, 0);
        op("sub_3c_5a", 8'h3c, 8'h5a, 1, 8'he2, 1);

        send(8'h12, 8'h34, 0);
        wait_ov();
        r0 = result; c0 = cout;
        chk("bp_lit_r", r0, 8'h46);
        chk("bp_lit_c", c0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1 || i == 2); a = 8'h11; b = 8'h22; m = 0;
            @(posedge clk); #1;
            chk("bp_result", result, r0);
            chk("bp_cout", cout, c0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        op("after_bp", 8'h07, 8'h09, 0, 8'h10, 0);

        send(8'haa, 8'h55, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        rst = 0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        op("after_rst", 8'h01, 8'h01, 0, 8'h02, 0);

        a = 8'h80; b = 8'h80; m = 1; in_valid = 1; out_ready = 1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        a = 8'h00; b = 8'h01;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!in_ready && n < 30);
        chk("b2b_spacing", n + 1, 10);
        chk("b2b_first_r", result, 8'h00);
        chk("b2b_first_c", cout, 0);
        @(posedge clk); #1;
        in_valid = 0;
        wait_ov();
        chk("b2b_second_r", result, 8'hff);
        chk("b2b_second_c", cout, 1);
        @(posedge clk); #1;
        out_ready = 0;

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            recv($urandom_range(0, 3), rr, cc);
        end
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial unsigned adder/subtractor for the arithmetic-circuits library. It accepts two WIDTH-bit operands and a mode bit through a valid/ready handshake. It processes one bit per clock, LSB first, through a single full-adder/full-subtractor cell with a registered carry/borrow. It returns the WIDTH-bit result and the final carry-out/borrow-out through a second valid/ready handshake. It is the area-minimal, multi-cycle counterpart to the parallel add/sub cells, and is used where one gate-level bit cell per operation is preferred over WIDTH cells.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  first operand (minuend for subtract).
- b  input  WIDTH  second operand (subtrahend for subtract).
- m  input  1  mode: 0 = a + b, 1 = a - b.
- out_valid  output  1  result and cout valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry-out for add; borrow-out for subtract (1 iff a < b unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a clock edge: latch a, b and m into shift registers, clear carry/borrow register c to 0, clear bit counter to 0, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, bit cell takes ai = a_sh[0], bi = b_sh[0] and c.
    - Add: s = ai^bi^c; c_next = ai&bi | c&(ai^bi).
    - Subtract: s = ai^bi^c; c_next = ~ai&bi | c&~(ai^bi).
  - s shifts into result register MSB side (result shifts right). a_sh and b_sh shift right. Counter increments.
  - When counter == WIDTH-1, that bit is processed and the FSM goes to DONE.
- DONE:
  - out_valid = 1; result = full WIDTH-bit answer; cout = final c.
  - On out_valid & out_ready, go to IDLE. Result and cout registers hold their values.
  - in_ready stays 0 in DONE, including the output-handshake cycle. No same-cycle accept.
- Subtraction uses borrow propagation with initial borrow 0, not two's-complement +1. result equals (a - b) mod 2^WIDTH.
- Inputs a, b, m are sampled only at the accept edge. Later changes have no effect.
- in_valid during RUN or DONE is ignored (not queued).
- Counter width is max(1, clog2(WIDTH)).
- With WIDTH = 1, RUN lasts exactly one cycle.

## Timing
- Reset (rst high at an edge):
  - state = IDLE, result = 0, cout = 0, c = 0, counter = 0, out_valid = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst is released.
- Accept edge at cycle k. RUN occupies edges k+1 .. k+WIDTH. out_valid is high from cycle k+WIDTH (after edge k+WIDTH) until the output handshake edge.
- Latency: WIDTH cycles from accept edge to out_valid.
- Minimum period between accepts: WIDTH+2 cycles, with out_ready held high.
- Backpressure: while out_valid = 1 and out_ready = 0, result and cout are held stable, with no limit on hold time.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and never presented.
  - out_valid = 0 on the cycle after the reset edge.
  - The block is ready again one cycle after rst deasserts.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to either output.

## Test plan
- WIDTH=8, add:
  - a=0x5A, b=0x3C, m=0 -> result 0x96, cout 0, with out_valid rising exactly 8 cycles after the accept edge.
  - a=0xFF, b=0x01, m=0 -> result 0x00, cout 1.
- Subtract:
  - a=0x5A, b=0x3C, m=1 -> result 0x1E, cout 0.
  - a=0x3C, b=0x5A, m=1 -> result 0xE2, cout 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> result and cout unchanged and in_ready stays 0.
  - in_valid pulsed during that time with a=0x11, b=0x22 -> ignored; after release, next accepted operation is the one presented in IDLE.
- Input stability: change a, b, m every cycle during RUN -> result still equals the operation on the values latched at the accept edge.
- Reset mid-op:
  - Assert rst at RUN bit 4 -> no out_valid produced; in_ready = 1 the cycle after rst falls.
  - Then 0x01+0x01 -> result 0x02, cout 0.
- Back-to-back:
  - in_valid and out_ready held high, 0x80-0x80 then 0x00-0x01 -> results 0x00/cout 0 and 0xFF/cout 1.
  - Accepts are exactly 10 cycles apart.
